// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing constants for the 4x4 systolic sequencer.
// Everything here is referenced by the controller, its interface and the skew generator.
package systolic_pkg;

   localparam int N              = 4;
   localparam int K_DEPTH        = 16;
   localparam int ADDR_W         = 6;
   localparam int COMPUTE_CYCLES = K_DEPTH + 3 * (N - 1) + 1;
   localparam int CNT_W          = 5;
   localparam int BEAT_W         = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_COMPUTE,
      S_STORE,
      S_DRAIN,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host/datapath-facing bundle of the sequencer: source handshake plus the
// memory and array control strobes. master is the sequencer side.
interface systolic_seq_ctrl_if #(
   parameter int N      = systolic_pkg::N,
   parameter int ADDR_W = systolic_pkg::ADDR_W
);

   logic                  start;
   logic                  src_valid;
   logic [ADDR_W-1:0]     src_addr;
   logic                  load_ready;
   logic                  mem_clr;
   logic                  arr_clr;
   logic                  wr_en_ab;
   logic [ADDR_W-1:0]     wr_addr_ab;
   logic                  rd_en_ab;
   logic [N*ADDR_W-1:0]   rd_addr_a;
   logic [N*ADDR_W-1:0]   rd_addr_b;
   logic [N-1:0]          feed_en_a;
   logic [N-1:0]          feed_en_b;
   logic                  wr_en_c;
   logic                  rd_en_c;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, src_valid, src_addr,
      output load_ready, mem_clr, arr_clr, wr_en_ab, wr_addr_ab, rd_en_ab,
             rd_addr_a, rd_addr_b, feed_en_a, feed_en_b, wr_en_c, rd_en_c,
             busy, done
   );

   modport slave (
      output start, src_valid, src_addr,
      input  load_ready, mem_clr, arr_clr, wr_en_ab, wr_addr_ab, rd_en_ab,
             rd_addr_a, rd_addr_b, feed_en_a, feed_en_b, wr_en_c, rd_en_c,
             busy, done
   );

endinterface

// File: rtl/systolic_seq_ctrl_skew.sv
// Per-lane skewed read address generator: lane r reads word c-r while that
// index lies inside the inner product, and a registered valid follows the read data.
module skew_addr_gen #(
   parameter int N       = 4,
   parameter int K_DEPTH = 16,
   parameter int ADDR_W  = 6,
   parameter int CNT_W   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                active,
   input  logic [CNT_W-1:0]    cyc,
   output logic [N*ADDR_W-1:0] rd_addr,
   output logic [N-1:0]        feed_en
);

   logic [N-1:0] lane_vld;
   logic [N-1:0] feed_en_d;
   logic [N-1:0] feed_en_q;

   always_comb begin
      lane_vld = '0;
      rd_addr  = '0;
      for (int r = 0; r < N; r++) begin
         if (active && (cyc >= CNT_W'(r)) &&
             ((cyc - CNT_W'(r)) <= CNT_W'(K_DEPTH - 1))) begin
            lane_vld[r]                  = 1'b1;
            rd_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(cyc - CNT_W'(r));
         end
      end
   end

   // Memory read data appears one cycle after the address, so the lane valid
   // is delayed by exactly one clock to line up with it.
   always_comb begin
      feed_en_d = lane_vld;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         feed_en_q <= '0;
      end else begin
         feed_en_q <= feed_en_d;
      end
   end

   assign feed_en = feed_en_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 4x4 systolic multiply: clear, load 16 operand beats,
// skewed compute, store results to Memory_C, drain them and pulse done.
module systolic_seq_ctrl #(
   parameter int N              = systolic_pkg::N,
   parameter int K_DEPTH        = systolic_pkg::K_DEPTH,
   parameter int ADDR_W         = systolic_pkg::ADDR_W,
   parameter int COMPUTE_CYCLES = systolic_pkg::COMPUTE_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_seq_ctrl_if.master  bus
);

   import systolic_pkg::*;

   localparam int DRN_W = $clog2(N);

   seq_state_t          state_q, state_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]    cyc_q, cyc_d;
   logic [DRN_W-1:0]    drn_q, drn_d;
   logic                compute_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         cyc_q      <= '0;
         drn_q      <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         cyc_q      <= cyc_d;
         drn_q      <= drn_d;
      end
   end

   // Each counter is zeroed on entry to the state that uses it, so none can
   // carry stale counts from an earlier or abandoned job.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      cyc_d      = cyc_q;
      drn_d      = drn_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d    = S_LOAD;
            beat_cnt_d = '0;
         end
         S_LOAD: begin
            if (bus.src_valid) begin
               if (beat_cnt_q == BEAT_W'(K_DEPTH - 1)) begin
                  state_d = S_COMPUTE;
                  cyc_d   = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (cyc_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
               state_d = S_STORE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_STORE: begin
            state_d = S_DRAIN;
            drn_d   = '0;
         end
         S_DRAIN: begin
            if (drn_q == DRN_W'(N - 1)) begin
               state_d = S_DONE;
            end else begin
               drn_d = drn_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.load_ready = 1'b0;
      bus.mem_clr    = 1'b0;
      bus.arr_clr    = 1'b0;
      bus.wr_en_ab   = 1'b0;
      bus.wr_addr_ab = '0;
      bus.rd_en_ab   = 1'b0;
      bus.wr_en_c    = 1'b0;
      bus.rd_en_c    = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      case (state_q)
         S_CLEAR: begin
            bus.mem_clr  = 1'b1;
            bus.arr_clr  = 1'b1;
            bus.wr_en_ab = 1'b1;
         end
         S_LOAD: begin
            bus.load_ready = 1'b1;
            if (bus.src_valid) begin
               bus.wr_en_ab   = 1'b1;
               bus.wr_addr_ab = bus.src_addr;
            end
         end
         S_COMPUTE: begin
            bus.rd_en_ab = 1'b1;
            bus.busy     = 1'b1;
         end
         S_STORE: begin
            bus.wr_en_c = 1'b1;
            bus.busy    = 1'b1;
         end
         S_DRAIN: begin
            bus.rd_en_c = 1'b1;
            bus.busy    = 1'b1;
         end
         S_DONE: begin
            bus.done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign compute_act = (state_q == S_COMPUTE);

   skew_addr_gen #(
      .N       (N),
      .K_DEPTH (K_DEPTH),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W)
   ) u_skew_a (
      .clk     (clk),
      .rst     (rst),
      .active  (compute_act),
      .cyc     (cyc_q),
      .rd_addr (bus.rd_addr_a),
      .feed_en (bus.feed_en_a)
   );

   skew_addr_gen #(
      .N       (N),
      .K_DEPTH (K_DEPTH),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W)
   ) u_skew_b (
      .clk     (clk),
      .rst     (rst),
      .active  (compute_act),
      .cyc     (cyc_q),
      .rd_addr (bus.rd_addr_b),
      .feed_en (bus.feed_en_b)
   );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed job scenarios plus random traffic,
// every cycle compared against a job-timeline reference model.
module tb_systolic_seq_ctrl;

   import systolic_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int errors   = 0;
   int cyc_n    = 0;
   int clr_cyc  = -1;
   int done_cyc = -1;
   int clr_n    = 0;
   int done_n   = 0;
   int fa_cnt [N];
   int fb_cnt [N];

   // Reference model: a job is a timeline of CLEAR, a beat-count-driven load,
   // then fixed offsets k after the last beat (compute, store, drain, done).
   bit           m_job   = 1'b0;
   bit           m_ld    = 1'b0;
   int           m_e     = 0;
   int           m_beats = 0;
   int           m_k     = 0;
   logic [N-1:0] m_fe    = '0;

   always #5 clk = ~clk;

   systolic_seq_ctrl_if bus_if ();

   systolic_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_n);
      end
   endtask

   function automatic void lanes(input int k, input bit comp,
                                 output logic [N*ADDR_W-1:0] addr, output logic [N-1:0] flg);
      addr = '0;
      flg  = '0;
      for (int r = 0; r < N; r++) begin
         if (comp && (k - r) >= 0 && (k - r) < K_DEPTH) begin
            flg[r]                    = 1'b1;
            addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(k - r);
         end
      end
   endfunction

   task automatic step(input bit r, input bit s, input bit v, input logic [ADDR_W-1:0] a);
      bit clr, ld, acc, comp, stor, drn, dn;
      logic [N*ADDR_W-1:0] e_addr;
      logic [N-1:0]        e_flg;
      logic [N*ADDR_W-1:0] skew3;
      @(negedge clk);
      rst              = r;
      bus_if.start     = s;
      bus_if.src_valid = v;
      bus_if.src_addr  = a;
      #1;
      clr  = m_job && m_e == 0;
      ld   = m_job && m_e == 1 && !m_ld;
      acc  = ld && v;
      comp = m_job && m_ld && m_k < COMPUTE_CYCLES;
      stor = m_job && m_ld && m_k == COMPUTE_CYCLES;
      drn  = m_job && m_ld && m_k > COMPUTE_CYCLES && m_k <= COMPUTE_CYCLES + N;
      dn   = m_job && m_ld && m_k == COMPUTE_CYCLES + N + 1;
      lanes(m_k, comp, e_addr, e_flg);
      check_eq("load_ready", 32'(bus_if.load_ready), 32'(ld));
      check_eq("mem_clr",    32'(bus_if.mem_clr),    32'(clr));
      check_eq("arr_clr",    32'(bus_if.arr_clr),    32'(clr));
      check_eq("wr_en_ab",   32'(bus_if.wr_en_ab),   32'(clr || acc));
      check_eq("wr_addr_ab", 32'(bus_if.wr_addr_ab), acc ? 32'(a) : 32'd0);
      check_eq("rd_en_ab",   32'(bus_if.rd_en_ab),   32'(comp));
      check_eq("rd_addr_a",  32'(bus_if.rd_addr_a),  32'(e_addr));
      check_eq("rd_addr_b",  32'(bus_if.rd_addr_b),  32'(e_addr));
      check_eq("feed_en_a",  32'(bus_if.feed_en_a),  32'(m_fe));
      check_eq("feed_en_b",  32'(bus_if.feed_en_b),  32'(m_fe));
      check_eq("wr_en_c",    32'(bus_if.wr_en_c),    32'(stor));
      check_eq("rd_en_c",    32'(bus_if.rd_en_c),    32'(drn));
      check_eq("busy",       32'(bus_if.busy),       32'(comp || stor || drn));
      check_eq("done",       32'(bus_if.done),       32'(dn));
      if (comp && m_k == 3) begin
         skew3 = {6'd0, 6'd1, 6'd2, 6'd3};
         check_eq("skew_c3", 32'(bus_if.rd_addr_a), 32'(skew3));
      end
      if (comp && m_k == 19) check_eq("skew_c19_zero", 32'(bus_if.rd_addr_a), 32'd0);
      if (bus_if.mem_clr) begin
         clr_cyc = cyc_n;
         clr_n++;
         for (int i = 0; i < N; i++) begin
            fa_cnt[i] = 0;
            fb_cnt[i] = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (bus_if.feed_en_a[i]) fa_cnt[i]++;
         if (bus_if.feed_en_b[i]) fb_cnt[i]++;
      end
      if (bus_if.done) begin
         done_cyc = cyc_n;
         done_n++;
      end
      @(posedge clk);
      if (r) begin
         m_job = 1'b0;
         m_fe  = '0;
      end else begin
         m_fe = e_flg;
         if (!m_job) begin
            if (s) begin
               m_job   = 1'b1;
               m_e     = 0;
               m_ld    = 1'b0;
               m_beats = 0;
            end
         end else if (m_e == 0) begin
            m_e = 1;
         end else if (!m_ld) begin
            if (v) begin
               m_beats++;
               if (m_beats == K_DEPTH) begin
                  m_ld = 1'b1;
                  m_k  = 0;
               end
            end
         end else begin
            m_k++;
            if (m_k == COMPUTE_CYCLES + N + 2) m_job = 1'b0;
         end
      end
      cyc_n++;
   endtask

   task automatic beats(input int n, input int stall_at, input int stall_len, input bit s);
      for (int b = 0; b < n; b++) begin
         if (b == stall_at) begin
            for (int i = 0; i < stall_len; i++) step(1'b0, s, 1'b0, ADDR_W'(b));
         end
         step(1'b0, s, 1'b1, ADDR_W'(b));
      end
   endtask

   task automatic wait_done(input bit s, input int budget);
      int d0;
      d0 = done_n;
      for (int i = 0; i < budget && done_n == d0; i++) step(1'b0, s, 1'b0, '0);
      check_eq("done_seen", 32'(done_n - d0), 32'd1);
   endtask

   task automatic job(input int stall_at, input int stall_len);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      beats(K_DEPTH, stall_at, stall_len, 1'b0);
      wait_done(1'b0, 40);
      check_eq("latency", 32'(done_cyc - clr_cyc), 32'(48 + stall_len));
   endtask

   initial begin
      int d0;
      int c1;
      bus_if.start     = 1'b0;
      bus_if.src_valid = 1'b0;
      bus_if.src_addr  = '0;
      repeat (3) @(posedge clk);
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);

      // nominal job, then the operand counts feeding each PE (A=1, B=2)
      job(-1, 0);
      check_eq("wr_c_len", 32'(done_cyc - clr_cyc), 32'd48);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            check_eq("pe_acc", 32'(((fa_cnt[i] < fb_cnt[j]) ? fa_cnt[i] : fb_cnt[j]) * 1 * 2), 32'd32);
         end
      end
      step(1'b0, 1'b0, 1'b0, '0);

      // load stall of 5 cycles after 7 beats
      job(7, 5);
      step(1'b0, 1'b0, 1'b0, '0);

      // reset in COMPUTE at c=10, then a fresh job
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      beats(K_DEPTH, -1, 0, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b0, '0);
      d0 = done_n;
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (40) step(1'b0, 1'b0, 1'b0, '0);
      check_eq("no_done_after_rst", 32'(done_n - d0), 32'd0);
      job(-1, 0);

      // start held high through a whole job
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      d0 = clr_n;
      beats(K_DEPTH, -1, 0, 1'b1);
      wait_done(1'b1, 40);
      check_eq("no_restart", 32'(clr_n - d0), 32'd0);
      c1 = done_cyc;
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      check_eq("restart_gap", 32'(clr_cyc - c1), 32'd2);
      beats(K_DEPTH, -1, 0, 1'b0);
      wait_done(1'b0, 40);

      // reset in LOAD after 9 beats; next job needs all 16
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      beats(9, -1, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      beats(K_DEPTH - 1, -1, 0, 1'b0);
      #2;
      check_eq("load_after_15", 32'(bus_if.load_ready), 32'd1);
      check_eq("no_compute_15", 32'(bus_if.rd_en_ab), 32'd0);
      step(1'b0, 1'b0, 1'b1, ADDR_W'(15));
      wait_done(1'b0, 40);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 500) == 0, ($urandom % 4) == 0, ($urandom % 3) != 0,
              ADDR_W'($urandom));
      end
      repeat (2) step(1'b1, 1'b0, 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish cycle=%0d", cyc_n);
      $fatal(1, "watchdog");
   end

endmodule
